// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-file slave.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package apb_pkg;

    // Transfer FSM: IDLE waits for an access phase, WAIT burns the
    // programmed wait states, RESP is the single PREADY cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

    // Byte address bits below this one select a byte within a word.
    localparam int WORD_LSB = 2;

    // Word index from a byte address. Callers zero-extend PADDR to 32 bits.
    function automatic logic [31:0] word_index(input logic [31:0] paddr);
        return paddr >> WORD_LSB;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage with byte-lane writes and a read mux that returns
// either stored words or the live read-only inputs.
// Latency: write lands at the clock edge of wr_en_i; read path is combinational.
// Backpressure: none; the caller decides when to write.
//
// Ports:
//   PCLK, PRESET   clock, asynchronous active-high reset
//   wr_en_i        commit a write this cycle (caller has already checked index/RO)
//   wr_idx_i       target word index
//   wr_dat_i       write data
//   wr_strb_i      byte-lane enables
//   rd_idx_i       read word index (must be < NUM_REGS to be meaningful)
//   rd_dat_o       read data: stored word, or ro_d_i slot for read-only words
//   ro_d_i         flattened read-only values
//   reg_q_o        flattened stored words; read-only slots drive 0
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int                    DATA_W   = 32,
    parameter int                    NUM_REGS = 8,
    parameter int                    IDX_W    = 3,
    parameter logic [NUM_REGS-1:0]   RO_MASK  = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         wr_en_i,
    input  logic [IDX_W-1:0]             wr_idx_i,
    input  logic [DATA_W-1:0]            wr_dat_i,
    input  logic [DATA_W/8-1:0]          wr_strb_i,
    input  logic [IDX_W-1:0]             rd_idx_i,
    output logic [DATA_W-1:0]            rd_dat_o,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_d_i,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q_o
);

    localparam int NB = DATA_W / 8;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            // Read-only words have no flops; their slot reads as zero.
            assign reg_q_o[i*DATA_W +: DATA_W] = '0;
        end else begin : g_rw
            logic [DATA_W-1:0] word_q;

            always_ff @(posedge PCLK or posedge PRESET) begin
                if (PRESET) begin
                    word_q <= '0;
                end else if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_strb_i[b]) begin
                            word_q[b*8 +: 8] <= wr_dat_i[b*8 +: 8];
                        end
                    end
                end
            end

            assign reg_q_o[i*DATA_W +: DATA_W] = word_q;
        end
    end

    always_comb begin
        rd_dat_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_dat_o = RO_MASK[i] ? ro_d_i[i*DATA_W +: DATA_W]
                                      : reg_q_o[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3 register-file slave: NUM_REGS words of DATA_W bits, RO mapping, byte strobes.
// Latency: access phase of WAIT_STATES+2 cycles counted from the edge the
//          slave first samples PSEL&PENABLE; PREADY/PSLVERR/PRDATA registered.
// Backpressure: PREADY held low until the wait counter expires; PREADY pulses one cycle.
//
// Ports:
//   PCLK, PRESET          APB clock, asynchronous active-high reset
//   PADDR, PWRITE, PSEL,
//   PENABLE, PWDATA, PSTRB   APB3 request
//   PRDATA, PREADY, PSLVERR  APB3 response (all registered)
//   reg_q                 flattened RW register contents to peripheral logic
//   ro_d                  flattened read-only values from peripheral logic
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                    DATA_W      = 32,
    parameter int                    ADDR_W      = 8,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic                         PWRITE,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W/8-1:0]          PSTRB,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_d
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_state_e          state_q;
    logic [3:0]          cnt_q;
    logic                pready_q;
    logic                pslverr_q;
    logic [DATA_W-1:0]   prdata_q;

    logic [31:0]         idx;
    logic [IDX_W-1:0]    idx_s;
    logic                idx_ok;
    logic                ro_hit;
    logic                err;
    logic                access;
    logic                complete;
    logic                wr_en;
    logic [DATA_W-1:0]   rd_dat;

    // Address and control are only looked at on the completion edge;
    // APB holds them stable throughout the access phase.
    assign idx      = word_index(32'(PADDR));
    assign idx_s    = idx[IDX_W-1:0];
    assign idx_ok   = (idx < 32'(NUM_REGS));
    assign ro_hit   = idx_ok && RO_MASK[idx_s];
    assign err      = !idx_ok || (PWRITE && ro_hit);
    assign access   = PSEL && PENABLE;
    assign complete = (state_q == WAIT) && access && (cnt_q == 4'd0);
    assign wr_en    = complete && PWRITE && !err;

    apb_reg_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .RO_MASK  (RO_MASK)
    ) u_bank (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx_s),
        .wr_dat_i  (PWDATA),
        .wr_strb_i (PSTRB),
        .rd_idx_i  (idx_s),
        .rd_dat_o  (rd_dat),
        .ro_d_i    (ro_d),
        .reg_q_o   (reg_q)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            // Response outputs are single-cycle pulses; default them low.
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (access) begin
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!access) begin
                        // Master abandoned the transfer: drop it silently.
                        cnt_q   <= 4'd0;
                        state_q <= IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= err;
                        prdata_q  <= (!PWRITE && !err) ? rd_dat : '0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
module tb_apb_regfile_slave;

    logic         PCLK;
    logic         PRESET;
    logic         preset_c;
    logic [7:0]   PADDR;
    logic         PWRITE;
    logic         PENABLE;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic         psel_a, psel_b, psel_c;

    logic [31:0]  prdata_a, prdata_b, prdata_c;
    logic         pready_a, pready_b, pready_c;
    logic         pslverr_a, pslverr_b, pslverr_c;
    logic [255:0] regq_a, regq_b, regq_c;
    logic [255:0] ro_a;
    logic [255:0] ro_zero;

    int total;
    int bad;

    // A: no wait states, word 2 read-only.  B: two wait states.  C: three wait states, own reset.
    apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(8), .WAIT_STATES(0), .RO_MASK(8'h04)) dut_a (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(psel_a),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata_a),
        .PREADY(pready_a), .PSLVERR(pslverr_a), .reg_q(regq_a), .ro_d(ro_a));

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(8), .WAIT_STATES(2), .RO_MASK(8'h00)) dut_b (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(psel_b),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata_b),
        .PREADY(pready_b), .PSLVERR(pslverr_b), .reg_q(regq_b), .ro_d(ro_zero));

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(8), .WAIT_STATES(3), .RO_MASK(8'h00)) dut_c (
        .PCLK(PCLK), .PRESET(preset_c), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(psel_c),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata_c),
        .PREADY(pready_c), .PSLVERR(pslverr_c), .reg_q(regq_c), .ro_d(ro_zero));

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [255:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    function automatic logic rdy(input int d);
        case (d)
            0:       return pready_a;
            1:       return pready_b;
            default: return pready_c;
        endcase
    endfunction

    function automatic logic [31:0] rdat_of(input int d);
        case (d)
            0:       return prdata_a;
            1:       return prdata_b;
            default: return prdata_c;
        endcase
    endfunction

    function automatic logic err_of(input int d);
        case (d)
            0:       return pslverr_a;
            1:       return pslverr_b;
            default: return pslverr_c;
        endcase
    endfunction

    task automatic drive_setup(input int d, input logic [7:0] addr, input logic wr,
                               input logic [31:0] wdat, input logic [3:0] strb);
        @(posedge PCLK); #1;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wdat;
        PSTRB   = strb;
        psel_a  = (d == 0);
        psel_b  = (d == 1);
        psel_c  = (d == 2);
        PENABLE = 1'b0;
    endtask

    // Full transfer. 'edges' counts clock edges after PENABLE goes high until
    // PREADY is seen; the transfer then completes on the following edge.
    task automatic apb_xfer(input int d, input logic [7:0] addr, input logic wr,
                            input logic [31:0] wdat, input logic [3:0] strb,
                            output logic [31:0] rdat, output logic err, output int edges);
        drive_setup(d, addr, wr, wdat, strb);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        edges = 0;
        do begin
            @(posedge PCLK); #1;
            edges++;
        end while (!rdy(d) && edges < 40);
        rdat = rdat_of(d);
        err  = err_of(d);
    endtask

    task automatic bus_idle();
        @(posedge PCLK); #1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        psel_c  = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        logic [31:0]  rd;
        logic         er;
        int           ed;
        logic [255:0] exp_a;
        logic         seen;

        total = 0;
        bad   = 0;
        ro_zero = '0;
        for (int i = 0; i < 8; i++) ro_a[i*32 +: 32] = 32'h5555_0000 + 32'(i);
        ro_a[2*32 +: 32] = 32'hCAFE_0001;
        PADDR = '0; PWRITE = 0; PENABLE = 0; PWDATA = '0; PSTRB = '0;
        psel_a = 0; psel_b = 0; psel_c = 0;
        PRESET = 1'b1; preset_c = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_pready_a",  256'(pready_a),  256'(0));
        chk("rst_pslverr_a", 256'(pslverr_a), 256'(0));
        chk("rst_prdata_a",  256'(prdata_a),  256'(0));
        chk("rst_regq_a",    regq_a, '0);
        chk("rst_regq_b",    regq_b, '0);
        PRESET = 1'b0; preset_c = 1'b0;

        // Basic write/read, zero wait states
        apb_xfer(0, 8'h04, 1'b1, 32'hDEADBEEF, 4'hF, rd, er, ed);
        chk("wr1_edges", 256'(ed), 256'(2));
        chk("wr1_err",   256'(er), 256'(0));
        bus_idle();
        chk("wr1_reg1",  256'(word_of(regq_a, 1)), 256'(32'hDEADBEEF));
        chk("pready_one_cycle_a", 256'(pready_a), 256'(0));
        apb_xfer(0, 8'h04, 1'b0, 32'h0, 4'h0, rd, er, ed);
        chk("rd1_data",  256'(rd), 256'(32'hDEADBEEF));
        chk("rd1_err",   256'(er), 256'(0));
        chk("rd1_edges", 256'(ed), 256'(2));

        // Byte strobes: lanes 0 and 2 only; low address bits ignored
        apb_xfer(0, 8'h07, 1'b1, 32'h11223344, 4'b0101, rd, er, ed);
        bus_idle();
        chk("strb_reg1", 256'(word_of(regq_a, 1)), 256'(32'hDE22BE44));

        // PSTRB=0 is a no-op without error
        apb_xfer(0, 8'h04, 1'b1, 32'h0BAD0BAD, 4'h0, rd, er, ed);
        chk("nostrb_err", 256'(er), 256'(0));
        bus_idle();
        chk("nostrb_reg1", 256'(word_of(regq_a, 1)), 256'(32'hDE22BE44));

        // Out of range index 8
        exp_a = '0;
        exp_a[1*32 +: 32] = 32'hDE22BE44;
        apb_xfer(0, 8'h20, 1'b1, 32'hFFFFFFFF, 4'hF, rd, er, ed);
        chk("oor_wr_err", 256'(er), 256'(1));
        bus_idle();
        chk("oor_wr_regq", regq_a, exp_a);
        apb_xfer(0, 8'h20, 1'b0, 32'h0, 4'h0, rd, er, ed);
        chk("oor_rd_data", 256'(rd), 256'(0));
        chk("oor_rd_err",  256'(er), 256'(1));
        bus_idle();

        // Read-only word 2
        apb_xfer(0, 8'h08, 1'b1, 32'h12345678, 4'hF, rd, er, ed);
        chk("ro_wr_err",  256'(er), 256'(1));
        chk("ro_wr_data", 256'(rd), 256'(0));
        bus_idle();
        chk("ro_wr_regq", regq_a, exp_a);
        apb_xfer(0, 8'h08, 1'b0, 32'h0, 4'h0, rd, er, ed);
        chk("ro_rd_data", 256'(rd), 256'(32'hCAFE0001));
        chk("ro_rd_err",  256'(er), 256'(0));
        apb_xfer(0, 8'h0C, 1'b0, 32'h0, 4'h0, rd, er, ed);
        chk("rw_rd_reg3", 256'(rd), 256'(0));
        bus_idle();

        // Two wait states
        apb_xfer(1, 8'h00, 1'b0, 32'h0, 4'h0, rd, er, ed);
        chk("ws2_edges", 256'(ed), 256'(4));
        chk("ws2_rdata", 256'(rd), 256'(0));
        bus_idle();
        chk("ws2_pready_drop", 256'(pready_b), 256'(0));

        // Back-to-back writes on the two-wait-state slave
        apb_xfer(1, 8'h00, 1'b1, 32'hA5A5A5A5, 4'hF, rd, er, ed);
        chk("b2b_edges0", 256'(ed), 256'(4));
        apb_xfer(1, 8'h08, 1'b1, 32'h0F0F0F0F, 4'hF, rd, er, ed);
        chk("b2b_edges1", 256'(ed), 256'(4));
        bus_idle();
        chk("b2b_reg0", 256'(word_of(regq_b, 0)), 256'(32'hA5A5A5A5));
        chk("b2b_reg2", 256'(word_of(regq_b, 2)), 256'(32'h0F0F0F0F));

        // Abandoned access in WAIT: no write, no PREADY
        drive_setup(1, 8'h04, 1'b1, 32'h77777777, 4'hF);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        psel_b = 1'b0;
        PENABLE = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge PCLK); #1;
            if (pready_b) seen = 1'b1;
        end
        chk("abort_no_pready", 256'(seen), 256'(0));
        chk("abort_no_write",  256'(word_of(regq_b, 1)), 256'(0));

        // Reset in the middle of WAIT (three wait states)
        apb_xfer(2, 8'h04, 1'b1, 32'h12345678, 4'hF, rd, er, ed);
        chk("ws3_edges", 256'(ed), 256'(5));
        bus_idle();
        chk("ws3_reg1", 256'(word_of(regq_c, 1)), 256'(32'h12345678));
        drive_setup(2, 8'h00, 1'b1, 32'h99999999, 4'hF);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        preset_c = 1'b1;
        #1;
        chk("midrst_pready",  256'(pready_c),  256'(0));
        chk("midrst_pslverr", 256'(pslverr_c), 256'(0));
        chk("midrst_prdata",  256'(prdata_c),  256'(0));
        chk("midrst_regq",    regq_c, '0);
        bus_idle();
        @(posedge PCLK); #1;
        preset_c = 1'b0;
        apb_xfer(2, 8'h00, 1'b0, 32'h0, 4'h0, rd, er, ed);
        chk("postrst_edges", 256'(ed), 256'(5));
        chk("postrst_rdata", 256'(rd), 256'(0));
        bus_idle();
        chk("postrst_regq", regq_c, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
Parametrised APB3 register-file slave, the next generation of the team's fixed 4 x 32-bit APB slave. Adds configurable register count and data width, per-register read-only mapping, byte-lane write strobes, programmable wait states and PSLVERR signalling. Sits on the APB fabric behind the bus decoder. Exposes register contents to the peripheral logic, and takes read-only values back from it.

Parameters:
DATA_W, 32, data width in bits; a multiple of 8, maximum 64.
ADDR_W, 8, PADDR width; must be at least clog2(NUM_REGS)+2.
NUM_REGS, 8, number of word registers, 1..64.
WAIT_STATES, 0, extra access-phase cycles inserted before PREADY, 0..15.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from ro_d.

Ports:
PCLK  in  1  APB clock.
PRESET  in  1  asynchronous active-high reset.
PADDR  in  ADDR_W  byte address; word index = PADDR[ADDR_W-1:2]; PADDR[1:0] ignored.
PWRITE  in  1  1 = write, 0 = read.
PSEL  in  1  slave select.
PENABLE  in  1  access phase.
PWDATA  in  DATA_W  write data.
PSTRB  in  DATA_W/8  byte-lane write enables.
PRDATA  out  DATA_W  read data.
PREADY  out  1  transfer complete.
PSLVERR  out  1  transfer error; valid only while PREADY=1.
reg_q  out  NUM_REGS*DATA_W  flattened RW register contents; register i at [i*DATA_W +: DATA_W].
ro_d  in  NUM_REGS*DATA_W  flattened read-only values; only slots with RO_MASK set are used.

Behaviour:
- Reset is PRESET, asynchronous, active-high; clock is PCLK.
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, every reg_q word=0, FSM=IDLE, wait counter=0.
- FSM states are IDLE, WAIT and RESP. PREADY, PSLVERR and PRDATA are all registered.
- IDLE: when PSEL&PENABLE is sampled, load the counter with WAIT_STATES and go to WAIT.
- WAIT: if the counter is not 0, decrement it. If the counter is 0, complete the transfer at this edge and go to RESP.
- On completion, PREADY=1 for exactly one cycle, during the RESP state.
- RESP always returns to IDLE. PREADY, PSLVERR and PRDATA go back to 0.
- Back-to-back transfers work because the next APB setup cycle has PENABLE=0.
- Access phase length is WAIT_STATES+2 cycles. With WAIT_STATES=0 this matches the previous generation (one wait cycle).
- Write completion: if the index is valid and RO_MASK[idx]=0, update each byte lane b with PSTRB[b]=1 from PWDATA. Lanes with PSTRB[b]=0 keep their value. PSTRB=0 is a legal no-op with PSLVERR=0.
- Read completion: PRDATA = reg_q word for RW registers, or ro_d word sampled at the completion edge for RO registers.
- Errors: an index >= NUM_REGS, or a write to an RO register, gives PSLVERR=1 together with PREADY. No state changes, and PRDATA=0.
- Address and control are sampled at the completion edge. The APB protocol guarantees they are stable during the access phase.
- PSEL or PENABLE falling in WAIT is a protocol violation: return to IDLE with no write and no PREADY.
- PRESET during WAIT or RESP aborts immediately. All registers clear and no partial write survives.
- Read-only registers have no storage. Their reg_q slot drives 0.

Decomposition:
- Package apb_pkg holds:
  - the state enum typedef (IDLE, WAIT, RESP);
  - the constant WORD_LSB=2;
  - a function computing the word index from PADDR.
- One sub-module, apb_reg_bank, is natural. It holds:
  - the NUM_REGS x DATA_W storage;
  - the byte-strobe write logic;
  - the RO_MASK and ro_d read mux.
- The FSM, wait counter and error decode stay in the top level.

Test Plan:
- Reset: assert PRESET in the middle of WAIT with WAIT_STATES=3 -> PREADY=0, PSLVERR=0, PRDATA=0 and all reg_q=0 in the same cycle.
- Basic RW (WAIT_STATES=0): write 0xDEADBEEF to 0x04 with PSTRB=0xF -> PREADY high in the 2nd access cycle, reg_q word1=0xDEADBEEF. Read 0x04 -> PRDATA=0xDEADBEEF, PSLVERR=0.
- Strobes: with reg1=0xDEADBEEF, write 0x11223344 to 0x04 with PSTRB=0b0101 -> reg1=0xDE22BE44.
- Wait states (WAIT_STATES=2): read 0x00 -> access phase lasts exactly 4 cycles, PREADY high for 1 cycle. Back-to-back writes to 0x00 and 0x08 both land.
- Out of range (NUM_REGS=8): write 0xFFFFFFFF to 0x20 -> PSLVERR=1 with PREADY, no reg_q change. Read 0x20 -> PRDATA=0, PSLVERR=1.
- Read-only (RO_MASK=0x04, ro_d word2=0xCAFE0001): write 0x12345678 to 0x08 -> PSLVERR=1. Read 0x08 -> PRDATA=0xCAFE0001, PSLVERR=0.
